// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of mem_ctrl. Port 0 is the
// instruction-fetch requester and port 1 is the load/store requester. One
// transaction is granted at a time. The command goes to mem_ctrl as a
// one-cycle O_exec pulse. Read data and a one-cycle done pulse return to the
// port that was granted.
//
// Ports
//   I_clk, I_rst_n            clock; asynchronous active-low reset
//   I_pX_req                  port X request level, held until O_pX_done
//   I_pX_write                port X write (1) / read (0)
//   I_pX_addr, I_pX_data      port X address and write data
//   O_pX_rdata                port X read data (registered)
//   O_pX_done                 port X completion, one-cycle pulse
//   O_exec/O_write/O_addr/O_data  command to mem_ctrl (registered)
//   I_ready, I_data_ready     status from mem_ctrl
//   I_mem_data                read data from mem_ctrl
//
// Every output is a flop. I_ready never reaches O_exec combinationally,
// because mem_ctrl's ready depends on its exec input.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          I_clk,
  input  logic          I_rst_n,

  input  logic          I_p0_req,
  input  logic          I_p0_write,
  input  logic [AW-1:0] I_p0_addr,
  input  logic [DW-1:0] I_p0_data,
  output logic [DW-1:0] O_p0_rdata,
  output logic          O_p0_done,

  input  logic          I_p1_req,
  input  logic          I_p1_write,
  input  logic [AW-1:0] I_p1_addr,
  input  logic [DW-1:0] I_p1_data,
  output logic [DW-1:0] O_p1_rdata,
  output logic          O_p1_done,

  output logic          O_exec,
  output logic          O_write,
  output logic [AW-1:0] O_addr,
  output logic [DW-1:0] O_data,
  input  logic          I_ready,
  input  logic          I_data_ready,
  input  logic [DW-1:0] I_mem_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_WAIT_WR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Port that won the most recent grant. It resets to 1, so port 0 takes
  // the first tie.
  logic r_last_grant;
  logic w_last_grant_nxt;

  // Port that owns the transaction in flight.
  logic r_gnt;
  logic w_gnt_nxt;

  logic          w_exec_nxt;
  logic          w_write_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_data_nxt;
  logic [DW-1:0] w_p0_rdata_nxt;
  logic [DW-1:0] w_p1_rdata_nxt;
  logic          w_p0_done_nxt;
  logic          w_p1_done_nxt;

  // A port whose done is high this cycle still has its old request asserted.
  // Masking it here prevents that stale request from being granted again.
  logic w_p0_elig;
  logic w_p1_elig;
  logic w_any_elig;
  logic w_sel;

  assign w_p0_elig  = I_p0_req & ~O_p0_done;
  assign w_p1_elig  = I_p1_req & ~O_p1_done;
  assign w_any_elig = w_p0_elig | w_p1_elig;
  // On a tie the port that did not win last time gets the grant.
  assign w_sel      = (w_p0_elig & w_p1_elig) ? ~r_last_grant : w_p1_elig;

  // State and output registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      O_exec       <= 1'b0;
      O_write      <= 1'b0;
      O_addr       <= '0;
      O_data       <= '0;
      O_p0_rdata   <= '0;
      O_p1_rdata   <= '0;
      O_p0_done    <= 1'b0;
      O_p1_done    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      O_exec       <= w_exec_nxt;
      O_write      <= w_write_nxt;
      O_addr       <= w_addr_nxt;
      O_data       <= w_data_nxt;
      O_p0_rdata   <= w_p0_rdata_nxt;
      O_p1_rdata   <= w_p1_rdata_nxt;
      O_p0_done    <= w_p0_done_nxt;
      O_p1_done    <= w_p1_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    // Every register holds by default. The exec and done pulses default low.
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_exec_nxt       = 1'b0;
    w_write_nxt      = O_write;
    w_addr_nxt       = O_addr;
    w_data_nxt       = O_data;
    w_p0_rdata_nxt   = O_p0_rdata;
    w_p1_rdata_nxt   = O_p1_rdata;
    w_p0_done_nxt    = 1'b0;
    w_p1_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (I_ready && w_any_elig) begin
          w_gnt_nxt        = w_sel;
          w_last_grant_nxt = w_sel;
          w_exec_nxt       = 1'b1;
          w_state_nxt      = S_ISSUE;
          if (w_sel) begin
            w_write_nxt = I_p1_write;
            w_addr_nxt  = I_p1_addr;
            w_data_nxt  = I_p1_data;
          end else begin
            w_write_nxt = I_p0_write;
            w_addr_nxt  = I_p0_addr;
            w_data_nxt  = I_p0_data;
          end
        end
      end

      // mem_ctrl takes the command on this cycle's closing edge. Exec drops
      // here, so the pulse lasts exactly one cycle.
      S_ISSUE: begin
        w_state_nxt = O_write ? S_WAIT_WR : S_WAIT_RD;
      end

      // mem_ctrl clears data_ready on the accept edge. Any data_ready seen
      // here therefore belongs to the current read.
      S_WAIT_RD: begin
        if (I_data_ready) begin
          w_state_nxt = S_IDLE;
          if (r_gnt) begin
            w_p1_rdata_nxt = I_mem_data;
            w_p1_done_nxt  = 1'b1;
          end else begin
            w_p0_rdata_nxt = I_mem_data;
            w_p0_done_nxt  = 1'b1;
          end
        end
      end

      S_WAIT_WR: begin
        if (I_ready) begin
          w_state_nxt = S_IDLE;
          if (r_gnt) begin
            w_p1_done_nxt = 1'b1;
          end else begin
            w_p0_done_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_write, p1_req, p1_write;
  logic [15:0] p0_addr, p0_data, p1_addr, p1_data;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done;
  logic        o_exec, o_write;
  logic [15:0] o_addr, o_data;
  logic        ready, data_ready;
  logic [15:0] mem_data;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_p0_req(p0_req), .I_p0_write(p0_write), .I_p0_addr(p0_addr), .I_p0_data(p0_data),
    .O_p0_rdata(p0_rdata), .O_p0_done(p0_done),
    .I_p1_req(p1_req), .I_p1_write(p1_write), .I_p1_addr(p1_addr), .I_p1_data(p1_data),
    .O_p1_rdata(p1_rdata), .O_p1_done(p1_done),
    .O_exec(o_exec), .O_write(o_write), .O_addr(o_addr), .O_data(o_data),
    .I_ready(ready), .I_data_ready(data_ready), .I_mem_data(mem_data)
  );

  // ---------------- mem_ctrl model (no reset, like the real one) ----------
  logic        m_ready = 1'b1;
  logic        m_dr    = 1'b0;
  logic [15:0] m_data  = 16'h0;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  logic        m_wr    = 1'b0;
  logic [15:0] m_addr  = 16'h0;
  logic        stall;
  int          lat;
  logic [15:0] mem [0:255];

  assign ready      = m_ready & ~stall;
  assign data_ready = m_dr;
  assign mem_data   = m_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h04] = 16'hBEEF;   // addr 0x0040
    mem[8'h10] = 16'h1111;   // addr 0x0100
    mem[8'h20] = 16'h2222;   // addr 0x0200
  end

  always @(posedge clk) begin
    if (o_exec) begin
      m_ready <= 1'b0;
      m_dr    <= 1'b0;
      m_busy  <= 1'b1;
      m_cnt   <= lat - 1;
      m_wr    <= o_write;
      m_addr  <= o_addr;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        if (!m_wr) begin
          m_dr   <= 1'b1;
          m_data <= mem[m_addr[11:4]];
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_done;
    bit          port;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic exp_cmd(input bit wr, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.is_done = 1'b0; e.port = 1'b0; e.wr = wr; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_done(input bit p, input bit wr, input logic [15:0] rd);
    ev_t e;
    e.is_done = 1'b1; e.port = p; e.wr = wr; e.addr = 16'h0; e.data = rd;
    q.push_back(e);
  endtask

  // Monitor: pops on every exec or done pulse and tracks expected rdata.
  logic [15:0] exp_rd [2];
  logic        prev_exec, prev_d0, prev_d1;
  ev_t         me;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      prev_exec = 1'b0; prev_d0 = 1'b0; prev_d1 = 1'b0;
    end else begin
      if (o_exec) begin
        chk("exec_width", {31'b0, prev_exec}, 32'd0);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL exec_unexpected actual=addr %h required=no command at %0t", o_addr, $time);
        end else begin
          me = q.pop_front();
          chk("exec_kind", {31'b0, me.is_done}, 32'd0);
          chk("exec_write", {31'b0, o_write}, {31'b0, me.wr});
          chk("exec_addr", {16'b0, o_addr}, {16'b0, me.addr});
          chk("exec_data", {16'b0, o_data}, {16'b0, me.data});
        end
      end
      if (p0_done || p1_done) begin
        chk("done_both", {31'b0, p0_done & p1_done}, 32'd0);
        chk("done_width", {31'b0, p1_done ? prev_d1 : prev_d0}, 32'd0);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected actual=port %0d required=no done at %0t", p1_done, $time);
        end else begin
          me = q.pop_front();
          chk("done_kind", {31'b0, me.is_done}, 32'd1);
          chk("done_port", {31'b0, p1_done}, {31'b0, me.port});
          if (!me.wr) exp_rd[me.port] = me.data;
        end
      end
      chk("p0_rdata", {16'b0, p0_rdata}, {16'b0, exp_rd[0]});
      chk("p1_rdata", {16'b0, p1_rdata}, {16'b0, exp_rd[1]});
      prev_exec = o_exec; prev_d0 = p0_done; prev_d1 = p1_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input bit p);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(p ? p1_done : p0_done) && n < 200);
    if (!(p ? p1_done : p0_done)) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no done required=done on port %0d", p);
    end
  endtask

  task automatic run_both(input int n);
    int c0 = 0, c1 = 0, k = 0;
    p0_req = 1'b1; p1_req = 1'b1;
    while ((c0 < n || c1 < n) && k < 400) begin
      @(posedge clk); #1; k++;
      if (p0_done) begin c0++; if (c0 == n) p0_req = 1'b0; end
      if (p1_done) begin c1++; if (c1 == n) p1_req = 1'b0; end
    end
    if (c0 < n || c1 < n) begin
      checks++; failures++;
      $display("FAIL both_timeout actual=%0d/%0d required=%0d each", c0, c1, n);
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exec"},  {31'b0, o_exec},  32'd0);
    chk({tag, "_write"}, {31'b0, o_write}, 32'd0);
    chk({tag, "_addr"},  {16'b0, o_addr},  32'd0);
    chk({tag, "_data"},  {16'b0, o_data},  32'd0);
    chk({tag, "_p0rd"},  {16'b0, p0_rdata}, 32'd0);
    chk({tag, "_p1rd"},  {16'b0, p1_rdata}, 32'd0);
    chk({tag, "_p0dn"},  {31'b0, p0_done}, 32'd0);
    chk({tag, "_p1dn"},  {31'b0, p1_done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; lat = 1;
    p0_req = 0; p0_write = 0; p0_addr = 0; p0_data = 0;
    p1_req = 0; p1_write = 0; p1_addr = 0; p1_data = 0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single read on port 0
    lat = 3;
    exp_cmd(1'b0, 16'h0040, 16'h0000);
    exp_done(1'b0, 1'b0, 16'hBEEF);
    p0_write = 0; p0_addr = 16'h0040; p0_data = 16'h0000; p0_req = 1;
    wait_done(1'b0);
    p0_req = 0;
    chk("t1_addr_hold", {16'b0, o_addr}, 32'h0040);

    // 2: single write on port 1 with ready low for two cycles
    lat = 2;
    exp_cmd(1'b1, 16'h1234, 16'h00FF);
    exp_done(1'b1, 1'b1, 16'h0000);
    p1_write = 1; p1_addr = 16'h1234; p1_data = 16'h00FF; p1_req = 1;
    wait_done(1'b1);
    p1_req = 0;
    chk("t2_write_hold", {31'b0, o_write}, 32'd1);
    chk("t2_data_hold", {16'b0, o_data}, 32'h00FF);

    // 3: both ports held, four transactions, strict alternation
    lat = 1;
    p0_write = 0; p0_addr = 16'h0100; p0_data = 16'h0000;
    p1_write = 0; p1_addr = 16'h0200; p1_data = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      exp_cmd(1'b0, 16'h0100, 16'h0000); exp_done(1'b0, 1'b0, 16'h1111);
      exp_cmd(1'b0, 16'h0200, 16'h0000); exp_done(1'b1, 1'b0, 16'h2222);
    end
    run_both(2);

    // 4: port 0 keeps its request through the done cycle
    p0_write = 1; p0_addr = 16'h0050; p0_data = 16'hCAFE;
    for (int i = 0; i < 2; i++) begin
      exp_cmd(1'b1, 16'h0050, 16'hCAFE); exp_done(1'b0, 1'b1, 16'h0000);
    end
    p0_req = 1;
    wait_done(1'b0);
    @(posedge clk); #1 chk("t4_no_regrant", {31'b0, o_exec}, 32'd0);
    @(posedge clk); #1 chk("t4_regrant", {31'b0, o_exec}, 32'd1);
    wait_done(1'b0);
    p0_req = 0;

    // 5: backpressure for ten cycles with port 1 requesting
    stall = 1;
    p1_write = 0; p1_addr = 16'h0040; p1_data = 16'h0000; p1_req = 1;
    exp_cmd(1'b0, 16'h0040, 16'h0000); exp_done(1'b1, 1'b0, 16'hBEEF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 chk("t5_stalled", {31'b0, o_exec}, 32'd0);
    end
    stall = 0;
    @(posedge clk); #1 chk("t5_grant_after_ready", {31'b0, o_exec}, 32'd1);
    wait_done(1'b1);
    p1_req = 0;

    // 6: reset while a read is outstanding
    lat = 10;
    p0_write = 0; p0_addr = 16'h0100; p0_data = 16'h0000;
    exp_cmd(1'b0, 16'h0100, 16'h0000);
    p0_req = 1;
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!o_exec && n < 50);
      chk("t6_exec_seen", {31'b0, o_exec}, 32'd1);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    q.delete();
    p0_req = 0;
    repeat (15) @(posedge clk);
    #1 chk("t6_no_done0", {31'b0, p0_done}, 32'd0);
    chk("t6_no_rdata0", {16'b0, p0_rdata}, 32'd0);
    rst_n = 1'b1;
    lat = 1;
    p0_addr = 16'h0040; p1_write = 0; p1_addr = 16'h0200; p1_data = 16'h0000;
    exp_cmd(1'b0, 16'h0040, 16'h0000); exp_done(1'b0, 1'b0, 16'hBEEF);
    exp_cmd(1'b0, 16'h0200, 16'h0000); exp_done(1'b1, 1'b0, 16'h2222);
    run_both(1);

    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
